// File: rtl/sparse_buffer_pkg.sv
// ----------------------------------------------------------------------------
// sparse_buffer_pkg
// Shared constants and width helpers for the sparse buffer datapath.
//   SB_DEFAULT_DEPTH : default number of entries
//   sb_ptr_w()       : pointer width for a given depth (count width is +1)
//   sb_ptr_t/sb_cnt_t: pointer/count types for the default depth
// ----------------------------------------------------------------------------
package sparse_buffer_pkg;

  localparam int SB_DEFAULT_DEPTH = 8;

  function automatic int sb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int SB_DEFAULT_PTR_W = sb_ptr_w(SB_DEFAULT_DEPTH);

  typedef logic [SB_DEFAULT_PTR_W-1:0] sb_ptr_t;
  typedef logic [SB_DEFAULT_PTR_W:0]   sb_cnt_t;

endpackage

// File: rtl/sparse_buffer_ptr_ctrl_if.sv
// ----------------------------------------------------------------------------
// sparse_buffer_ptr_ctrl_if
// Bundles the allocation/free handshake and status outputs of the sparse
// buffer pointer controller.
//   master : the client (drives alloc/free requests, observes status)
//   slave  : the controller
// ----------------------------------------------------------------------------
interface sparse_buffer_ptr_ctrl_if
  import sparse_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEFAULT_DEPTH
) ();

  localparam int PTR_W = sb_ptr_w(DEPTH);

  logic             alloc_valid_i;
  logic             alloc_ready_o;
  logic [PTR_W-1:0] alloc_ptr_o;
  logic             free_valid_i;
  logic [PTR_W-1:0] free_ptr_i;
  logic [DEPTH-1:0] entry_valid_o;
  logic [PTR_W-1:0] top_ptr_o;
  logic [PTR_W-1:0] bottom_ptr_o;
  logic [PTR_W:0]   count_o;
  logic             full_o;
  logic             empty_o;
  logic             err_o;

  modport master (
    output alloc_valid_i, free_valid_i, free_ptr_i,
    input  alloc_ready_o, alloc_ptr_o, entry_valid_o, top_ptr_o,
           bottom_ptr_o, count_o, full_o, empty_o, err_o
  );

  modport slave (
    input  alloc_valid_i, free_valid_i, free_ptr_i,
    output alloc_ready_o, alloc_ptr_o, entry_valid_o, top_ptr_o,
           bottom_ptr_o, count_o, full_o, empty_o, err_o
  );

endinterface

// File: rtl/sparse_buffer_ptr_ctrl_find_first.sv
// ----------------------------------------------------------------------------
// sb_circ_find_first
// Combinational circular first-set search: starting at start_i and scanning
// upward with wrap, returns the index of the first set bit of vec_i.
//   vec_i   : DEPTH-bit vector to search
//   start_i : index where the scan begins
//   idx_o   : first set index (start_i when nothing is set)
//   found_o : high when any bit of vec_i is set
// ----------------------------------------------------------------------------
module sb_circ_find_first
  import sparse_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEFAULT_DEPTH
) (
  input  logic [DEPTH-1:0]           vec_i,
  input  logic [sb_ptr_w(DEPTH)-1:0] start_i,
  output logic [sb_ptr_w(DEPTH)-1:0] idx_o,
  output logic                       found_o
);

  localparam int PTR_W = sb_ptr_w(DEPTH);

  logic [PTR_W-1:0] k;

  // Walk offsets from farthest to nearest so the nearest hit is written last
  // and wins. The PTR_W-bit add wraps naturally because DEPTH is a power of 2.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    idx_o   = start_i;
    found_o = 1'b0;
    k       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      k = start_i + PTR_W'(i);
      if (vec_i[k]) begin
        idx_o   = k;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparse_buffer_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// sparse_buffer_ptr_ctrl
// Pointer controller for a circular buffer whose entries are allocated in
// order at the top and released out of order anywhere.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : sparse_buffer_ptr_ctrl_if.slave
//           alloc_valid_i/alloc_ready_o/alloc_ptr_o : in-order allocation
//           free_valid_i/free_ptr_i                 : out-of-order release
//           entry_valid_o, top_ptr_o, bottom_ptr_o, count_o, full_o,
//           empty_o, err_o                          : registered status
// Build option: SPARSE_BUF_FREE_CHECK_EN -- when defined, a free of an
// invalid entry pulses err_o and is otherwise ignored; when undefined err_o
// is tied low.
// ----------------------------------------------------------------------------
module sparse_buffer_ptr_ctrl
  import sparse_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEFAULT_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  sparse_buffer_ptr_ctrl_if.slave bus
);

  localparam int PTR_W = sb_ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] valid_q,  valid_d;
  logic [PTR_W-1:0] top_q,    top_d;
  logic [PTR_W-1:0] bottom_q, bottom_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             err_q,    err_d;

  logic             full;
  logic             alloc_fire;
  logic             free_hit;
  logic             free_clr;
  logic [PTR_W-1:0] scan_idx;
  logic             scan_found;

  // Readiness comes only from registered count, so a same-cycle free never
  // opens a slot for an allocation into a full buffer.
  assign full       = (count_q == CNT_W'(DEPTH));
  assign alloc_fire = bus.alloc_valid_i && !full;
  // The slot being allocated this cycle is still clear in valid_q, so a free
  // aimed at it is treated as a free of an invalid entry.
  assign free_hit   = bus.free_valid_i && valid_q[bus.free_ptr_i];
  // Clearing an already-clear bit is a no-op, so qualifying with free_hit
  // matches "every free clears its bit" when the check is disabled.
  assign free_clr   = free_hit;

`ifdef SPARSE_BUF_FREE_CHECK_EN
  assign err_d = bus.free_valid_i && !valid_q[bus.free_ptr_i];
`else
  assign err_d = 1'b0;
`endif

  always_comb begin
    valid_d = valid_q;
    if (free_clr)   valid_d[bus.free_ptr_i] = 1'b0;
    if (alloc_fire) valid_d[top_q]          = 1'b1;
    top_d   = alloc_fire ? top_q + PTR_W'(1) : top_q;
    count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(free_clr);
  end

  sb_circ_find_first #(
    .DEPTH (DEPTH)
  ) u_find_first (
    .vec_i   (valid_d),
    .start_i (bottom_q),
    .idx_o   (scan_idx),
    .found_o (scan_found)
  );

  // With nothing valid, bottom parks on top so empty implies bottom == top.
  assign bottom_d = scan_found ? scan_idx : top_d;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above, regardless of ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      top_q    <= '0;
      bottom_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      top_q    <= top_d;
      bottom_q <= bottom_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign bus.alloc_ready_o = !full;
  assign bus.alloc_ptr_o   = top_q;
  assign bus.entry_valid_o = valid_q;
  assign bus.top_ptr_o     = top_q;
  assign bus.bottom_ptr_o  = bottom_q;
  assign bus.count_o       = count_q;
  assign bus.full_o        = full;
  assign bus.empty_o       = (count_q == '0);
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_sparse_buffer_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sparse_buffer_ptr_ctrl
// Directed bench for sparse_buffer_ptr_ctrl at DEPTH=8. Inputs change #1
// after a rising edge; registered outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_sparse_buffer_ptr_ctrl;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_err;

  always #5 clk = ~clk;

  sparse_buffer_ptr_ctrl_if #(.DEPTH(DEPTH)) bus ();

  sparse_buffer_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid_i = 1'b0;
    bus.free_valid_i  = 1'b0;
    bus.free_ptr_i    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc_one();
    bus.alloc_valid_i = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic free_one(input logic [2:0] p);
    bus.free_valid_i = 1'b1;
    bus.free_ptr_i   = p;
    tick();
    idle_inputs();
  endtask

  task automatic check_state(input string tag, input logic [7:0] v,
                             input logic [2:0] top, input logic [2:0] bot,
                             input logic [3:0] cnt);
    check({tag, "_valid"},  32'(bus.entry_valid_o), 32'(v));
    check({tag, "_top"},    32'(bus.top_ptr_o),     32'(top));
    check({tag, "_bottom"}, 32'(bus.bottom_ptr_o),  32'(bot));
    check({tag, "_count"},  32'(bus.count_o),       32'(cnt));
    check({tag, "_empty"},  32'(bus.empty_o),       32'(cnt == 4'd0));
    check({tag, "_full"},   32'(bus.full_o),        32'(cnt == 4'd8));
  endtask

  initial begin
`ifdef SPARSE_BUF_FREE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    idle_inputs();
    #2;

    // Reset state
    do_reset();
    check_state("rst", 8'h00, 3'd0, 3'd0, 4'd0);
    check("rst_ready", 32'(bus.alloc_ready_o), 32'd1);
    check("rst_err",   32'(bus.err_o),         32'd0);

    // Fill: 9 back-to-back allocations, the 9th must be refused
    for (int i = 0; i < 9; i++) begin
      bus.alloc_valid_i = 1'b1;
      #1;
      check("fill_ready", 32'(bus.alloc_ready_o), (i < 8) ? 32'd1 : 32'd0);
      if (i < 8) check("fill_ptr", 32'(bus.alloc_ptr_o), 32'(i));
      tick();
    end
    idle_inputs();
    check_state("fill", 8'hFF, 3'd0, 3'd0, 4'd8);
    check("fill_ready_after", 32'(bus.alloc_ready_o), 32'd0);

    // Full + same-cycle free of entry 0: allocation still refused
    bus.alloc_valid_i = 1'b1;
    bus.free_valid_i  = 1'b1;
    bus.free_ptr_i    = 3'd0;
    #1;
    check("fullfree_ready", 32'(bus.alloc_ready_o), 32'd0);
    tick();
    idle_inputs();
    check_state("fullfree", 8'hFE, 3'd0, 3'd1, 4'd7);

    // Reset mid-traffic at count 5, with simultaneous alloc + free discarded
    do_reset();
    for (int i = 0; i < 5; i++) alloc_one();
    check_state("pre_rst", 8'h1F, 3'd5, 3'd0, 4'd5);
    rst = 1'b1;
    bus.alloc_valid_i = 1'b1;
    bus.free_valid_i  = 1'b1;
    bus.free_ptr_i    = 3'd0;
    tick();
    rst = 1'b0;
    idle_inputs();
    check_state("mid_rst", 8'h00, 3'd0, 3'd0, 4'd0);

    // Out-of-order free: alloc 0..3, free 1, 2, then 0
    for (int i = 0; i < 4; i++) alloc_one();
    free_one(3'd1);
    check_state("ooo_f1", 8'h0D, 3'd4, 3'd0, 4'd3);
    free_one(3'd2);
    check_state("ooo_f2", 8'h09, 3'd4, 3'd0, 4'd2);
    free_one(3'd0);
    check_state("ooo_f0", 8'h08, 3'd4, 3'd3, 4'd1);

    // Drain to empty with top=6
    alloc_one();
    alloc_one();
    free_one(3'd3);
    free_one(3'd4);
    free_one(3'd5);
    check_state("wrap_pre", 8'h00, 3'd6, 3'd6, 4'd0);

    // Wrap: alloc 6,7,0; free 7, 6, 0
    for (int i = 0; i < 3; i++) alloc_one();
    check_state("wrap_alloc", 8'hC1, 3'd1, 3'd6, 4'd3);
    free_one(3'd7);
    check_state("wrap_f7", 8'h41, 3'd1, 3'd6, 4'd2);
    free_one(3'd6);
    check_state("wrap_f6", 8'h01, 3'd1, 3'd0, 4'd1);
    free_one(3'd0);
    check_state("wrap_f0", 8'h00, 3'd1, 3'd1, 4'd0);

    // Simultaneous alloc + free of bottom at count 5
    for (int i = 0; i < 5; i++) alloc_one();
    check_state("sim_pre", 8'h3E, 3'd6, 3'd1, 4'd5);
    bus.alloc_valid_i = 1'b1;
    bus.free_valid_i  = 1'b1;
    bus.free_ptr_i    = 3'd1;
    tick();
    idle_inputs();
    check_state("sim", 8'h7C, 3'd7, 3'd2, 4'd5);

    // Illegal free of invalid entry 2
    do_reset();
    alloc_one();
    alloc_one();
    free_one(3'd2);
    check("illegal_err", 32'(bus.err_o), 32'(exp_err));
    check_state("illegal", 8'h03, 3'd2, 3'd0, 4'd2);
    tick();
    check("illegal_err_pulse", 32'(bus.err_o), 32'd0);

    // Free of the entry being allocated in the same cycle is illegal
    bus.alloc_valid_i = 1'b1;
    bus.free_valid_i  = 1'b1;
    bus.free_ptr_i    = 3'd2;
    tick();
    idle_inputs();
    check("samefree_err", 32'(bus.err_o), 32'(exp_err));
    check_state("samefree", 8'h07, 3'd3, 3'd0, 4'd3);
    tick();
    check("samefree_err_pulse", 32'(bus.err_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_buffer_ptr_ctrl.md
SPARSE_BUFFER_PTR_CTRL -- requirements
Module: sparse_buffer_ptr_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of entries; power of two, 4..64.
REQ-002 SHALL have localparam PTR_W = clog2(DEPTH): pointer width.
REQ-003 SHALL have port clk_i  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port alloc_valid_i  input  1: request to allocate one entry at top.
REQ-006 SHALL have port alloc_ready_o  output  1: allocation is accepted this cycle.
REQ-007 SHALL have port alloc_ptr_o  output  PTR_W: index granted to an accepted allocation; equals top_ptr_o.
REQ-008 SHALL have port free_valid_i  input  1: request to release one entry, out of order.
REQ-009 SHALL have port free_ptr_i  input  PTR_W: index to release.
REQ-010 SHALL have port entry_valid_o  output  DEPTH: registered per-entry valid vector.
REQ-011 SHALL have port top_ptr_o  output  PTR_W: next index to allocate.
REQ-012 SHALL have port bottom_ptr_o  output  PTR_W: oldest valid entry in circular order.
REQ-013 SHALL have port count_o  output  PTR_W+1: number of valid entries.
REQ-014 SHALL have ports full_o and empty_o  output  1 each: count_o==DEPTH and count_o==0 respectively.
REQ-015 SHALL have port err_o  output  1: illegal free detected; a one-cycle pulse.

Function
REQ-016 SHALL drive alloc_ready_o = !full_o from registered state only; a same-cycle free SHALL NOT make a full buffer accept an allocation.
REQ-017 On alloc_valid_i && alloc_ready_o, SHALL set entry_valid[top_ptr] and increment top_ptr modulo DEPTH (wrap DEPTH-1 -> 0); visible next cycle.
REQ-018 On a legal free_valid_i, SHALL clear entry_valid[free_ptr_i]; visible next cycle.
REQ-019 A legal free SHALL target a currently valid entry; freeing an invalid entry, including the entry being allocated this same cycle, SHALL be illegal.
REQ-020 On simultaneous accepted alloc and legal free, both updates SHALL apply and count_o SHALL be unchanged.
REQ-021 count_o SHALL update as +1 for alloc only, -1 for legal free only, and SHALL never leave 0..DEPTH.
REQ-022 Next bottom_ptr SHALL be the first set bit of the next-cycle valid vector, scanning circularly upward from the current bottom_ptr; registered, with 1-cycle latency matching entry_valid_o.
REQ-023 When the next valid vector is all zero, next bottom_ptr SHALL equal the next top_ptr, so that empty implies bottom_ptr_o == top_ptr_o.
REQ-024 Freeing the bottom entry while entries above it are already free SHALL move bottom_ptr_o past every freed entry in one cycle.

Reset
REQ-025 While rst_i is high at a clock edge, SHALL load entry_valid_o=0, top_ptr_o=0, bottom_ptr_o=0, count_o=0, err_o=0; the outputs then give empty_o=1, full_o=0, alloc_ready_o=1.
REQ-026 Reset SHALL take priority over a simultaneous alloc or free, which SHALL be discarded.

Configuration
REQ-027 Macro SPARSE_BUF_FREE_CHECK_EN defined: an illegal free SHALL pulse err_o for one cycle, leave all state unchanged, and not affect a same-cycle allocation.
REQ-028 Macro SPARSE_BUF_FREE_CHECK_EN undefined: err_o SHALL be tied 0, and every free SHALL clear its bit; count_o SHALL decrement only if that bit was set.

Structure
REQ-029 Package sparse_buffer_pkg SHALL hold SB_DEFAULT_DEPTH=8 and a parameterised pointer/count width helper typedef, shared with the sparse buffer datapath.
REQ-030 The circular first-set scan SHALL be sub-module sb_circ_find_first #(DEPTH).
REQ-031 sb_circ_find_first SHALL take the vector and start index, and return the index plus a found flag.

Verification (DEPTH=8)
REQ-032 Reset: assert rst_i 1 cycle mid-traffic with count 5 -> next cycle count_o=0, empty_o=1, top=bottom=0, entry_valid_o=8'h00.
REQ-033 Fill: 9 back-to-back allocs from reset -> alloc_ptr_o 0..7, full_o=1 after 8th, 9th not accepted (alloc_ready_o=0), entry_valid_o=8'hFF.
REQ-034 Out-of-order free: alloc 0..3, free 1, free 2 -> bottom stays 0; free 0 -> bottom_ptr_o=3 next cycle.
REQ-035 Wrap: top=6 and empty, alloc 6,7,0 -> top_ptr_o=1; free 7, then 6 -> bottom_ptr_o=0; free 0 -> empty, bottom=top=1.
REQ-036 Simultaneous: count 5, alloc + free of bottom entry same cycle -> count_o=5, bottom advances, top advances.
REQ-037 Illegal free of invalid entry 2 with macro -> err_o=1 for one cycle, count_o unchanged; without macro -> err_o=0, count_o unchanged.
